// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped interval timer:
//   - byte offsets of each register relative to BASE_ADDR
//   - bit positions inside TCON and the mask of its implemented bits
//   - register-select enum used by the address decoder
//   - addr_hit(): word-aligned address match (addr[1:0] never decoded)
// ---------------------------------------------------------------------------
package timer_pkg;

   localparam logic [31:0] TH_OFF      = 32'h0000_0000;
   localparam logic [31:0] TL_OFF      = 32'h0000_0004;
   localparam logic [31:0] TCON_OFF    = 32'h0000_0008;
   localparam logic [31:0] SYSTICK_OFF = 32'h0000_0014;

   localparam int TCON_EN   = 0;
   localparam int TCON_IEN  = 1;
   localparam int TCON_STAT = 2;

   localparam logic [31:0] TCON_MASK = 32'h0000_0007;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_TH,
      SEL_TL,
      SEL_TCON,
      SEL_SYSTICK
   } reg_sel_e;

   // Byte lanes are not decoded: the two low address bits are masked off.
   function automatic logic addr_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] off);
      return (addr & ~32'h3) == (base + off);
   endfunction

endpackage

// File: rtl/timer_peripheral_if.sv
// ---------------------------------------------------------------------------
// timer_peripheral_if
// CPU data-bus view of the timer.
//   addr   : byte address from the ALU result
//   wdata  : store data
//   MemRd  : load strobe
//   MemWr  : store strobe, committed at the clock edge
//   rdata  : load data, combinational from the timer
// Handshake: there is none. Every access completes in the cycle it is
// presented; a load returns data in the same cycle, a store lands at the
// next rising edge. No wait states, no ready signal.
// ---------------------------------------------------------------------------
interface timer_peripheral_if;

   logic [31:0] addr;
   logic [31:0] wdata;
   logic        MemRd;
   logic        MemWr;
   logic [31:0] rdata;

   modport master (output addr, output wdata, output MemRd, output MemWr,
                   input  rdata);

   modport slave  (input  addr, input  wdata, input  MemRd, input  MemWr,
                   output rdata);

endinterface

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Divides enabled clock cycles by PRESCALE. The count runs 0..PRESCALE-1
// while en=1; tick is high in the cycle where count==PRESCALE-1 and the
// count returns to 0 on that edge. With en=0 the count holds its value.
// Ports:
//   clk   in  clock
//   reset in  asynchronous active-low reset
//   en    in  count enable (TCON enable bit)
//   tick  out one-cycle increment strobe for TL
// ---------------------------------------------------------------------------
module timer_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(PRESCALE) + 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      tick    = 1'b0;
      count_d = count_q;
      if (en) begin
         if (count_q == LAST) begin
            tick    = 1'b1;
            count_d = '0;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/timer_peripheral.sv
// ---------------------------------------------------------------------------
// timer_peripheral
// Memory-mapped interval timer on the CPU data bus.
//   TH      BASE+0x00 RW  reload value
//   TL      BASE+0x04 RW  up-counter, reloads from TH on overflow
//   TCON    BASE+0x08 RW  [0] enable, [1] irq enable, [2] overflow status
//   SYSTICK BASE+0x14 RO  free-running cycle counter
// Ports:
//   clk    in  clock, all state on rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave modport of timer_peripheral_if (addr/wdata/MemRd/MemWr/rdata)
//   IRQ    out level interrupt = TCON[1] & TCON[2]
// ---------------------------------------------------------------------------
module timer_peripheral
   import timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
   parameter int          PRESCALE  = 1
) (
   input  logic               clk,
   input  logic               reset,
   timer_peripheral_if.slave  bus,
   output logic               IRQ
);

   logic [31:0] th_q, th_d;
   logic [31:0] tl_q, tl_d;
   logic [2:0]  tcon_q, tcon_d;
   logic [31:0] systick_q;

   reg_sel_e sel;
   logic     wr_th, wr_tl, wr_tcon;
   logic     tick;
   logic     ovf;

   timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .en    (tcon_q[TCON_EN]),
      .tick  (tick)
   );

   always_comb begin
      sel = SEL_NONE;
      if      (addr_hit(bus.addr, BASE_ADDR, TH_OFF))      sel = SEL_TH;
      else if (addr_hit(bus.addr, BASE_ADDR, TL_OFF))      sel = SEL_TL;
      else if (addr_hit(bus.addr, BASE_ADDR, TCON_OFF))    sel = SEL_TCON;
      else if (addr_hit(bus.addr, BASE_ADDR, SYSTICK_OFF)) sel = SEL_SYSTICK;
   end

   assign wr_th   = bus.MemWr && (sel == SEL_TH);
   assign wr_tl   = bus.MemWr && (sel == SEL_TL);
   assign wr_tcon = bus.MemWr && (sel == SEL_TCON);

   // A TL store pre-empts the tick entirely, so it also suppresses the
   // overflow event that tick would have produced.
   assign ovf = tick && (tl_q == 32'hFFFF_FFFF) && !wr_tl;

   always_comb begin
      th_d = wr_th ? bus.wdata : th_q;

      tl_d = tl_q;
      if (wr_tl)    tl_d = bus.wdata;
      else if (ovf) tl_d = th_q;          // old TH even if TH is stored this edge
      else if (tick) tl_d = tl_q + 32'd1;

      tcon_d = tcon_q;
      if (wr_tcon) tcon_d = bus.wdata[2:0] & TCON_MASK[2:0];
      // Status set overrides a simultaneous store so no interrupt is lost;
      // the decision uses the pre-edge irq-enable bit.
      if (ovf && tcon_q[TCON_IEN]) tcon_d[TCON_STAT] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th_q      <= '0;
         tl_q      <= '0;
         tcon_q    <= '0;
         systick_q <= '0;
      end else begin
         th_q      <= th_d;
         tl_q      <= tl_d;
         tcon_q    <= tcon_d;
         systick_q <= systick_q + 32'd1;
      end
   end

   always_comb begin
      bus.rdata = 32'h0;
      if (bus.MemRd) begin
         case (sel)
            SEL_TH:      bus.rdata = th_q;
            SEL_TL:      bus.rdata = tl_q;
            SEL_TCON:    bus.rdata = {29'h0, tcon_q};
            SEL_SYSTICK: bus.rdata = systick_q;
            default:     bus.rdata = 32'h0;
         endcase
      end
   end

   assign IRQ = tcon_q[TCON_IEN] & tcon_q[TCON_STAT];

endmodule

// File: tb/tb_timer_peripheral.sv
// ---------------------------------------------------------------------------
// tb_timer_peripheral
// Directed bench for timer_peripheral. Two instances share clock and reset:
// dut1 with PRESCALE=1 and dut4 with PRESCALE=4. Expected values are worked
// out by hand edge by edge in the comments next to each step.
// ---------------------------------------------------------------------------
module tb_timer_peripheral;

   localparam logic [31:0] BASE    = 32'h4000_0000;
   localparam logic [31:0] A_TH    = BASE + 32'h00;
   localparam logic [31:0] A_TL    = BASE + 32'h04;
   localparam logic [31:0] A_TCON  = BASE + 32'h08;
   localparam logic [31:0] A_HOLE  = BASE + 32'h0C;
   localparam logic [31:0] A_SYST  = BASE + 32'h14;

   logic clk;
   logic reset;
   logic irq1, irq4;

   int n_checks;
   int n_fail;

   logic [31:0] exp_q[$];

   timer_peripheral_if bus1();
   timer_peripheral_if bus4();

   timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1),
      .IRQ   (irq1)
   );

   timer_peripheral #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4),
      .IRQ   (irq4)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Store lands at the next rising edge; returns at posedge+1.
   task automatic wr(input bit which, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      if (which) begin bus4.addr = a; bus4.wdata = d; bus4.MemWr = 1'b1; end
      else       begin bus1.addr = a; bus1.wdata = d; bus1.MemWr = 1'b1; end
      @(posedge clk);
      #1;
      bus1.MemWr = 1'b0;
      bus4.MemWr = 1'b0;
   endtask

   // Combinational load, 1 time unit long, taken between edges.
   task automatic rd(input bit which, input logic [31:0] a, output logic [31:0] d);
      if (which) begin bus4.addr = a; bus4.MemRd = 1'b1; end
      else       begin bus1.addr = a; bus1.MemRd = 1'b1; end
      #1;
      d = which ? bus4.rdata : bus1.rdata;
      bus1.MemRd = 1'b0;
      bus4.MemRd = 1'b0;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] v, s0, s1;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus1.addr = '0; bus1.wdata = '0; bus1.MemRd = 1'b0; bus1.MemWr = 1'b0;
      bus4.addr = '0; bus4.wdata = '0; bus4.MemRd = 1'b0; bus4.MemWr = 1'b0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      // Post-reset state
      rd(0, A_TH, v);   check("rst_th", v, 32'h0);
      rd(0, A_SYST, v); check("rst_systick", v, 32'h0);

      // 1: build TL=5, IRQ=1, then async reset mid-count
      wr(0, A_TH, 32'h3);
      wr(0, A_TL, 32'hFFFF_FFFF);
      wr(0, A_TCON, 32'h3);           // E0: enabled, no tick yet
      step(3);                        // E1 reload->3, E2 4, E3 5
      rd(0, A_TL, v);   check("pre_rst_tl", v, 32'h5);
      check("pre_rst_irq", {31'h0, irq1}, 32'h1);
      reset = 1'b0;
      #1;
      check("async_rst_irq", {31'h0, irq1}, 32'h0);
      rd(0, A_TL, v);   check("async_rst_tl", v, 32'h0);
      rd(0, A_TH, v);   check("async_rst_th", v, 32'h0);
      rd(0, A_TCON, v); check("async_rst_tcon", v, 32'h0);
      rd(0, A_SYST, v); check("async_rst_systick", v, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // 2: overflow with irq
      wr(0, A_TH, 32'hFFFF_FFFC);
      wr(0, A_TL, 32'hFFFF_FFFE);
      wr(0, A_TCON, 32'h3);           // E0
      exp_q.push_back(32'hFFFF_FFFF); // E1
      exp_q.push_back(32'hFFFF_FFFC); // E2 reload
      exp_q.push_back(32'hFFFF_FFFD); // E3
      for (int i = 0; i < 3; i++) begin
         step(1);
         rd(0, A_TL, v);
         check("ovf_tl", v, exp_q.pop_front());
         check("ovf_irq", {31'h0, irq1}, (i >= 1) ? 32'h1 : 32'h0);
      end
      rd(0, A_TCON, v); check("ovf_tcon", v, 32'h7);

      // 3: clearing
      wr(0, A_TCON, 32'h3);           // E4: TL->FFFFFFFE, status cleared
      check("clr_irq", {31'h0, irq1}, 32'h0);
      rd(0, A_TCON, v); check("clr_tcon", v, 32'h3);
      wr(0, A_TCON, 32'h1);           // E5: TL->FFFFFFFF, IEN off
      rd(0, A_TL, v);   check("noien_pre_tl", v, 32'hFFFF_FFFF);
      step(1);                        // E6: reload, no status
      rd(0, A_TL, v);   check("noien_reload_tl", v, 32'hFFFF_FFFC);
      rd(0, A_TCON, v); check("noien_tcon", v, 32'h1);
      check("noien_irq", {31'h0, irq1}, 32'h0);

      // 4: collisions
      wr(0, A_TCON, 32'h0);           // tick still applied: TL->FFFFFFFD
      rd(0, A_TL, v);   check("dis_tick_applied", v, 32'hFFFF_FFFD);
      wr(0, A_TL, 32'hFFFF_FFFF);
      wr(0, A_TCON, 32'h3);
      wr(0, A_TCON, 32'h1);           // overflow edge: stat set wins
      rd(0, A_TCON, v); check("col_tcon", v, 32'h5);
      check("col_irq", {31'h0, irq1}, 32'h0);
      rd(0, A_TL, v);   check("col_reload_tl", v, 32'hFFFF_FFFC);
      wr(0, A_TL, 32'd10);            // store beats tick
      rd(0, A_TL, v);   check("col_tl_store", v, 32'd10);
      step(1);
      rd(0, A_TL, v);   check("col_tl_next", v, 32'd11);
      wr(0, A_TCON, 32'h0);           // TL->12, stop
      wr(0, A_TL, 32'hFFFF_FFFF);
      wr(0, A_TCON, 32'h1);
      wr(0, A_TH, 32'h55);            // reload edge: TL gets old TH
      rd(0, A_TL, v);   check("col_th_old", v, 32'hFFFF_FFFC);
      rd(0, A_TH, v);   check("col_th_new", v, 32'h55);
      wr(0, A_TCON, 32'h0);

      // 5: prescale=4 on dut4
      wr(1, A_TCON, 32'h1);           // F0, count=0
      step(3);
      rd(1, A_TL, v);   check("ps_tl_3clk", v, 32'd0);
      step(1);
      rd(1, A_TL, v);   check("ps_tl_4clk", v, 32'd1);
      step(4);
      rd(1, A_TL, v);   check("ps_tl_8clk", v, 32'd2);
      wr(1, A_TCON, 32'h0);           // count 0->1, then frozen
      step(3);
      rd(1, A_TL, v);   check("ps_frozen_tl", v, 32'd2);
      wr(1, A_TCON, 32'h1);           // count stays 1
      step(2);                        // 1->2, 2->3
      rd(1, A_TL, v);   check("ps_resume_no_tick", v, 32'd2);
      step(1);                        // tick: count was held, not reset
      rd(1, A_TL, v);   check("ps_resume_tick", v, 32'd3);

      // 6: bus corner cases
      rd(0, A_HOLE, v); check("bus_hole", v, 32'h0);
      bus1.addr = A_TH; bus1.MemRd = 1'b0;
      #1;
      check("bus_nord", bus1.rdata, 32'h0);
      rd(0, A_TH | 32'h2, v); check("bus_lowbits", v, 32'h55);
      step(1);
      rd(0, A_SYST, s0);
      wr(0, A_SYST, 32'h0);
      rd(0, A_SYST, s1); check("systick_wr_ignored", s1, s0 + 32'd1);
      step(5);
      rd(0, A_SYST, s1); check("systick_count", s1, s0 + 32'd6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
